// File: rtl/pc_unit_pkg.sv
// Shared constants for the fetch-PC unit: branch funct3 encodings and
// the default reset/trap vectors and sequential step.
package pc_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          DEFAULT_PC_STEP      = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Control/operand bundle between decode-execute and the fetch-PC unit.
// master: the stage driving control and operands; slave: pc_unit.
interface pc_unit_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            jump;
  logic            jalr;
  logic            branch;
  logic [2:0]      funct3;
  logic [XLEN-1:0] res_pc;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] pc;
  logic            taken;
  logic [XLEN-1:0] link_addr;
  logic            exc_misaligned;
  logic [XLEN-1:0] exc_addr;

  modport master (
    output stall, jump, jalr, branch, funct3, res_pc, rs1_data, rs2_data, imm,
    input  pc, taken, link_addr, exc_misaligned, exc_addr
  );

  modport slave (
    input  stall, jump, jalr, branch, funct3, res_pc, rs1_data, rs2_data, imm,
    output pc, taken, link_addr, exc_misaligned, exc_addr
  );
endinterface

// File: rtl/pc_unit_branch_cond.sv
// Combinational RV32I branch-condition evaluator; undefined funct3 codes
// resolve to "not taken".
module pc_unit_branch_cond
  import pc_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            cond
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (rs1_data == rs2_data);
  assign lt  = ($signed(rs1_data) < $signed(rs2_data));
  assign ltu = (rs1_data < rs2_data);

  always_comb begin
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = ~eq;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Fetch-PC register with JAL/JALR/branch redirect, stall with a single
// newest-wins pending redirect, and misaligned-target trap.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int              PC_STEP      = DEFAULT_PC_STEP,
  parameter int              ALIGN_BITS   = 2
) (
  input logic        clk,
  input logic        rst,
  pc_unit_if.slave   bus
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            exc_q, exc_d;
  logic [XLEN-1:0] exc_addr_q, exc_addr_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  logic            cond;
  logic            taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic            misaligned;

  pc_unit_branch_cond #(.XLEN(XLEN)) u_branch_cond (
    .funct3   (bus.funct3),
    .rs1_data (bus.rs1_data),
    .rs2_data (bus.rs2_data),
    .cond     (cond)
  );

  // jalr outranks jump/branch; jump and branch share the res_pc-relative adder.
  assign jalr_sum   = bus.rs1_data + bus.imm;
  assign target     = bus.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (bus.res_pc + bus.imm);
  assign taken      = bus.jalr | bus.jump | (bus.branch & cond);
  assign misaligned = taken & (|target[ALIGN_BITS-1:0]);

  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    pc_d          = pc_q;
    exc_d         = 1'b0;
    exc_addr_d    = exc_addr_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;

    if (!bus.stall) begin
      // A live redirect supersedes any pending one, so pending always drains here.
      pend_valid_d = 1'b0;
      if (misaligned) begin
        pc_d       = TRAP_VECTOR;
        exc_d      = 1'b1;
        exc_addr_d = target;
      end else if (taken) begin
        pc_d = target;
      end else if (pend_valid_q) begin
        pc_d = pend_target_q;
      end else begin
        pc_d = pc_q + STEP;
      end
    end else if (misaligned) begin
      exc_d         = 1'b1;
      exc_addr_d    = target;
      pend_valid_d  = 1'b1;
      pend_target_d = TRAP_VECTOR;
    end else if (taken) begin
      pend_valid_d  = 1'b1;
      pend_target_d = target;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_VECTOR;
      exc_q         <= 1'b0;
      exc_addr_q    <= '0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pc_q          <= pc_d;
      exc_q         <= exc_d;
      exc_addr_q    <= exc_addr_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.taken          = taken;
  assign bus.link_addr      = bus.res_pc + STEP;
  assign bus.exc_misaligned = exc_q;
  assign bus.exc_addr       = exc_addr_q;

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter generator; the next generation of the single-cycle next-PC logic.
- Owns the architectural fetch-PC register; applies sequential advance, JAL/JALR/conditional-branch redirects, stall and trap redirect.
- Evaluates all six RV32I branch conditions internally from rs1/rs2 instead of relying on an external zero flag.
- Sits between decode/execute (control and operands in) and instruction fetch (pc out); usable single-cycle (res_pc = pc) or pipelined (res_pc = EX-stage PC).

Parameters:
- XLEN, 32, data/address width.
- RESET_VECTOR, 32'h0000_0000, pc value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, pc loaded on misaligned-target exception.
- PC_STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, low target bits that must be zero (2 = 4-byte alignment; 1 reserved for compressed support).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold pc this cycle
- jump  input  1  JAL: target = res_pc + imm
- jalr  input  1  JALR: target = (rs1_data + imm) & ~1
- branch  input  1  conditional branch: target = res_pc + imm if condition true
- funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU
- res_pc  input  XLEN  PC of the instruction being resolved
- rs1_data  input  XLEN  operand 1
- rs2_data  input  XLEN  operand 2
- imm  input  XLEN  sign-extended immediate
- pc  output  XLEN  current fetch PC (registered)
- taken  output  1  combinational: redirect requested this cycle
- link_addr  output  XLEN  res_pc + PC_STEP, for rd writeback
- exc_misaligned  output  1  registered one-cycle exception pulse
- exc_addr  output  XLEN  faulting target, registered, held until next exception

Behaviour:
- Reset (clk edge with rst=1): pc=RESET_VECTOR, exc_misaligned=0, exc_addr=0, pending redirect cleared. rst overrides all other inputs.
- Priority when several controls are high: jalr > jump > branch. Undefined funct3 (010, 011) gives condition false.
- Condition: eq/ne on full XLEN; lt/ge signed; ltu/geu unsigned. All adds wrap modulo 2^XLEN.
- taken = jalr | jump | (branch & cond). Asserted regardless of stall.
- Misaligned check: the target is misaligned if target[ALIGN_BITS-1:0] != 0 (after JALR bit-0 clear). Checked only when taken.
- Next-cycle state priority, with no stall:
  - Misaligned taken: pc=TRAP_VECTOR, exc_misaligned=1, exc_addr=target.
  - Otherwise taken: pc=target.
  - Otherwise, pending redirect valid: pc=pending target, clear pending.
  - Otherwise: pc=pc+PC_STEP.
- Stall=1:
  - pc holds.
  - A taken (aligned) redirect is latched into a single pending register. A later taken redirect during the same stall overwrites it (newest wins).
  - A misaligned redirect during stall raises exc_misaligned immediately and latches pending = TRAP_VECTOR.
- exc_misaligned is high exactly one cycle per fault. exc_addr holds its value otherwise.
- Latency: a redirect decided in cycle N shows on pc in cycle N+1.
- Reset mid-stall discards the pending redirect.

Decomposition:
- Shared package holds:
  - funct3 branch encodings as named constants (BEQ..BGEU).
  - RESET_VECTOR and TRAP_VECTOR defaults.
  - PC_STEP constant.
- One sub-module: branch_cond (funct3, rs1_data, rs2_data -> cond), purely combinational, reused by the future pipelined hazard unit.

Test Plan:
- Reset then 3 free-running cycles: pc sequence 0x0, 0x4, 0x8, 0xC; exc_misaligned=0.
- BLT: res_pc=0x20, rs1=0xFFFF_FFFF, rs2=1, imm=0x10 -> taken=1, next pc=0x30. Same operands with BLTU -> taken=0, pc=pc+4.
- JALR: rs1=0x1001, imm=0x2 -> target=0x1002 (misaligned) -> exc_misaligned pulses once, exc_addr=0x1002, pc=0x100. With rs1=0x1001, imm=0x3 -> target 0x1004 accepted.
- Stall: stall=1 for 3 cycles with JAL in the first cycle (res_pc=0x40, imm=0x80) -> pc held. The cycle after stall drops, pc=0xC0. link_addr=0x44 during the JAL cycle.
- Simultaneous: jalr=1, jump=1, branch=1 with BEQ true -> JALR target used. rst=1 asserted during a stall with pending redirect -> pc=RESET_VECTOR, pending discarded, next pc=0x4.
- Wrap-around: pc at 0xFFFF_FFFC with no redirect -> next pc=0x0000_0000. Branch at res_pc=0x4, imm=-8 -> target 0xFFFF_FFFC.
